// File: rtl/wave_pkg.sv
// rtl/wave_pkg.sv - shared types and constants for the waveform mode controller
package wave_pkg;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'd0,
    MODE_TRIANGLE = 2'd1,
    MODE_SAWTOOTH = 2'd2,
    MODE_SQUARE   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    LOAD  = 2'd3
  } state_t;

  // 100 MHz / (2 * 255 steps) gives a 1 Hz triangle at WIDTH=8
  localparam int unsigned DEFAULT_PERIOD = 196078;

endpackage

// File: rtl/prog_tick_timer.sv
// rtl/prog_tick_timer.sv - runtime-programmable downcounter emitting one tick every period clocks
module prog_tick_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PERIOD_W-1:0] period,
  input  logic                load,
  input  logic                enable,
  output logic                tick
);

  logic [PERIOD_W-1:0] count;
  logic [PERIOD_W-1:0] reload;

  // a zero period behaves as one tick per clock
  assign reload = (period == '0) ? '0 : period - 1'b1;
  assign tick   = enable && !load && (count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= reload;
    end else if (enable) begin
      count <= (count == '0) ? reload : count - 1'b1;
    end
  end

endmodule

// File: rtl/wave_mode_controller.sv
// rtl/wave_mode_controller.sv - PWM/R2R level generator with boundary-synchronised mode changes
module wave_mode_controller #(
  parameter int                   WIDTH          = 8,
  parameter int                   PERIOD_W       = 24,
  parameter logic [PERIOD_W-1:0]  DEFAULT_PERIOD = PERIOD_W'(wave_pkg::DEFAULT_PERIOD)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [1:0]          cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
  output logic [WIDTH-1:0]    level,
  output logic [1:0]          mode_active,
  output logic                busy,
  output logic                cycle_done
);

  import wave_pkg::*;

  localparam logic [WIDTH-1:0] MAX = '1;

  state_t              state, state_next;
  mode_t               mode_r, pend_mode;
  logic [PERIOD_W-1:0] period_r, pend_period, pend_period_eff, timer_period;
  logic [WIDTH-1:0]    phase, next_level, next_phase;
  logic                dir_down, next_dir, wrap;
  logic                accept, tick, boundary, timer_load, timer_en;

  assign mode_active     = mode_r;
  assign accept          = cfg_valid && cfg_ready;
  assign pend_period_eff = (pend_period == '0) ? PERIOD_W'(1) : pend_period;

  // LOAD primes the timer with the incoming period so the first step lands period clocks later
  assign timer_period = (state == LOAD) ? pend_period_eff : period_r;
  assign timer_load   = (state == LOAD) || !enable;
  assign timer_en     = ((state == RUN) || (state == DRAIN)) && enable;

  prog_tick_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .period (timer_period),
    .load   (timer_load),
    .enable (timer_en),
    .tick   (tick)
  );

  always_comb begin
    next_level = level;
    next_phase = phase;
    next_dir   = dir_down;
    wrap       = 1'b0;
    unique case (mode_r)
      MODE_TRIANGLE: begin
        if (!dir_down) begin
          next_level = level + 1'b1;
          if (level == MAX - 1'b1) next_dir = 1'b1;
        end else begin
          next_level = level - 1'b1;
          if (level == WIDTH'(1)) begin
            next_dir = 1'b0;
            wrap     = 1'b1;
          end
        end
      end
      MODE_SAWTOOTH: begin
        next_phase = phase + 1'b1;
        next_level = next_phase;
        wrap       = (phase == MAX);
      end
      MODE_SQUARE: begin
        next_phase = phase + 1'b1;
        next_level = next_phase[WIDTH-1] ? MAX : '0;
        wrap       = (phase == MAX);
      end
      default: ;
    endcase
  end

  assign boundary = tick && wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      level       <= '0;
      phase       <= '0;
      dir_down    <= 1'b0;
      cycle_done  <= 1'b0;
      mode_r      <= MODE_OFF;
      period_r    <= DEFAULT_PERIOD;
      pend_mode   <= MODE_OFF;
      pend_period <= '0;
    end else begin
      cycle_done <= boundary;
      if (accept) begin
        pend_mode   <= mode_t'(cfg_mode);
        pend_period <= cfg_period;
      end
      if (state == LOAD) begin
        mode_r   <= pend_mode;
        period_r <= pend_period_eff;
        level    <= '0;
        phase    <= '0;
        dir_down <= 1'b0;
      end else if (!enable) begin
        level    <= '0;
        phase    <= '0;
        dir_down <= 1'b0;
      end else if (tick) begin
        level    <= next_level;
        phase    <= next_phase;
        dir_down <= next_dir;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = LOAD;
      RUN:     if (accept) state_next = ((mode_r == MODE_OFF) || !enable) ? LOAD : DRAIN;
      DRAIN:   if (!enable || boundary) state_next = LOAD;
      LOAD:    state_next = (pend_mode == MODE_OFF) ? IDLE : RUN;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state == IDLE) || (state == RUN);
    busy      = (state == DRAIN);
  end

endmodule

// File: tb/tb_wave_mode_controller.sv
// tb/tb_wave_mode_controller.sv - directed bench with a step-index reference model for wave_mode_controller
module tb_wave_mode_controller;

  localparam int W    = 4;
  localparam int PW   = 24;
  localparam int MAXV = 15;
  localparam int DEF  = 196078;

  logic          clk = 1'b0;
  logic          reset, enable, cfg_valid;
  logic [1:0]    cfg_mode;
  logic [PW-1:0] cfg_period;
  logic          cfg_ready, busy, cycle_done;
  logic [W-1:0]  level;
  logic [1:0]    mode_active;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wave_mode_controller #(.WIDTH(W), .PERIOD_W(PW)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_mode    (cfg_mode),
    .cfg_period  (cfg_period),
    .level       (level),
    .mode_active (mode_active),
    .busy        (busy),
    .cycle_done  (cycle_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: waveform position is a step index k within one cycle
  int m_mode, m_period, m_k, m_cnt, p_mode, p_period;
  bit m_pend, m_load, m_done, m_valid = 1'b0;

  function automatic int cyc_len(input int mode);
    case (mode)
      1:       return 2 * MAXV;
      2, 3:    return MAXV + 1;
      default: return 1;
    endcase
  endfunction

  function automatic int model_level(input int mode, input int k);
    case (mode)
      1:       return (k <= MAXV) ? k : 2 * MAXV - k;
      2:       return k;
      3:       return (k >= (MAXV + 1) / 2) ? MAXV : 0;
      default: return 0;
    endcase
  endfunction

  initial forever begin
    bit acc, stp, bnd;
    @(posedge clk);
    if (reset) begin
      m_mode = 0; m_period = DEF; m_k = 0; m_cnt = DEF;
      m_pend = 0; m_load = 0; m_done = 0; m_valid = 1;
    end else if (m_valid) begin
      acc = cfg_valid && !m_load && !m_pend;
      if (m_load) begin
        m_mode   = p_mode;
        m_period = (p_period == 0) ? 1 : p_period;
        m_k      = 0;
        m_cnt    = m_period;
        m_load   = 0;
        m_done   = 0;
      end else begin
        stp    = (m_mode != 0) && enable && (m_cnt == 1);
        bnd    = stp && ((m_k + 1) % cyc_len(m_mode) == 0);
        m_done = bnd;
        if (!enable) begin
          m_k = 0; m_cnt = m_period;
        end else if (m_mode != 0) begin
          if (stp) begin
            m_k = (m_k + 1) % cyc_len(m_mode); m_cnt = m_period;
          end else m_cnt--;
        end
        if (acc) begin
          p_mode = int'(cfg_mode); p_period = int'(cfg_period);
          if (m_mode == 0 || !enable) m_load = 1;
          else m_pend = 1;
        end else if (m_pend && (bnd || !enable)) begin
          m_pend = 0; m_load = 1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("level",       level,       model_level(m_mode, m_k));
      chk("mode_active", mode_active, m_mode);
      chk("busy",        busy,        m_pend);
      chk("cfg_ready",   cfg_ready,   !m_load && !m_pend);
      chk("cycle_done",  cycle_done,  m_done);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int mode, input int period);
    cfg_valid  = 1'b1;
    cfg_mode   = 2'(mode);
    cfg_period = PW'(period);
    tick();
    cfg_valid  = 1'b0;
  endtask

  task automatic wait_level(input int v, input int limit, input string name);
    int n = 0;
    while (level !== W'(v) && n < limit) begin tick(); n++; end
    chk(name, level, v);
  endtask

  task automatic wait_done(input int limit, input string name);
    int n = 0;
    while (cycle_done !== 1'b1 && n < limit) begin tick(); n++; end
    chk(name, cycle_done, 1);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_mode = 2'd0; cfg_period = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_level", level, 0);
    chk("rst_mode", mode_active, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_ready, 1);

    enable = 1'b1;
    send(1, 2);
    chk("tri_load_ready", cfg_ready, 0);
    chk("tri_load_busy", busy, 0);
    tick();
    chk("tri_mode", mode_active, 1);
    repeat (30) tick();
    chk("tri_peak", level, 15);
    repeat (30) tick();
    chk("tri_floor", level, 0);
    chk("tri_done", cycle_done, 1);
    tick();
    chk("tri_done_pulse", cycle_done, 0);

    wait_level(9, 40, "tri_reach9");
    send(2, 1);
    chk("drain_busy", busy, 1);
    chk("drain_ready", cfg_ready, 0);
    chk("drain_mode", mode_active, 1);
    wait_done(100, "drain_done");
    chk("drain_end_level", level, 0);
    tick();
    chk("saw_mode", mode_active, 2);
    repeat (15) tick();
    chk("saw_top", level, 15);
    tick();
    chk("saw_wrap", level, 0);
    chk("saw_done", cycle_done, 1);

    send(3, 0);
    chk("sq_drain_busy", busy, 1);
    wait_done(40, "sq_drain_done");
    tick();
    chk("sq_mode", mode_active, 3);
    repeat (7) tick();
    chk("sq_low", level, 0);
    tick();
    chk("sq_high", level, 15);
    repeat (7) tick();
    chk("sq_high_end", level, 15);
    tick();
    chk("sq_wrap", level, 0);
    chk("sq_done", cycle_done, 1);

    send(2, 1);
    wait_done(40, "saw2_drain_done");
    tick();
    chk("saw2_mode", mode_active, 2);
    send(1, 2);
    chk("en_drain_busy", busy, 1);
    wait_level(7, 20, "en_reach7");
    enable = 1'b0;
    tick();
    chk("en_off_level", level, 0);
    chk("en_off_busy", busy, 0);
    chk("en_off_mode_kept", mode_active, 2);
    tick();
    chk("en_off_loaded", mode_active, 1);
    repeat (3) tick();
    chk("en_off_hold", level, 0);
    enable = 1'b1;
    tick();
    chk("en_resume_wait", level, 0);
    tick();
    chk("en_resume_step", level, 1);

    send(2, 5);
    chk("rst_pend_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_mode", mode_active, 0);
    chk("rst2_busy", busy, 0);
    repeat (10) tick();
    chk("rst2_discard_mode", mode_active, 0);
    chk("rst2_discard_level", level, 0);
    chk("rst2_ready", cfg_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog at %0t: got timeout expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
